// File: rtl/dice_roller_pkg.sv
// Shared types and constants for the dice roller core and its LFSR.
// The no-repeat option (DICE_ROLLER_NO_REPEAT_EN) lives in dice_roller_core.
package dice_roller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } state_e;

  // Taps for x^16+x^14+x^13+x^11+1 in the right-shifting form (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; it advances on every clock, whatever the roller is doing.
module dice_lfsr
  import dice_roller_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsrNext(state_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/dice_roller_core.sv
// Dice roller: a roll shows SLOW_STEPS LFSR samples at ever slower intervals, with history and lucky match.
// Defining DICE_ROLLER_NO_REPEAT_EN bumps an update by one whenever it would repeat the shown value.
module dice_roller_core
  import dice_roller_pkg::*;
#(
  parameter int          DW          = 4,
  parameter int          HIST_DEPTH  = 2,
  parameter int          SLOW_STEPS  = 8,
  parameter int          BASE_PERIOD = 2,
  parameter int          STEP        = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_capture,
  input  logic                            i_set_lucky,
  output logic [DW-1:0]                   o_value,
  output logic [DW-1:0]                   o_lucky,
  output logic [HIST_DEPTH*DW-1:0]        o_history,
  output logic [$clog2(HIST_DEPTH+1)-1:0] o_hist_count,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_match
);

  localparam int CNT_W = $clog2(BASE_PERIOD + (SLOW_STEPS - 1) * STEP + 1);
  localparam int K_W   = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;
  localparam int HC_W  = $clog2(HIST_DEPTH + 1);

  logic [15:0] lfsrState;
  logic        unusedLfsr;

  state_e                   state_q, state_d;
  logic [K_W-1:0]           stepIdx_q, stepIdx_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DW-1:0]            value_q, value_d;
  logic                     done_q, done_d;
  logic [DW-1:0]            lucky_q, lucky_d;
  logic                     luckyValid_q, luckyValid_d;
  logic [HIST_DEPTH*DW-1:0] hist_q, hist_d;
  logic [HC_W-1:0]          histCount_q, histCount_d;

  logic [CNT_W-1:0] periodLast;
  logic [DW-1:0]    lfsrLow;
  logic [DW-1:0]    rollValue;

  dice_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_state (lfsrState)
  );

  assign unusedLfsr = ^lfsrState;
  assign lfsrLow    = lfsrState[DW-1:0];

`ifdef DICE_ROLLER_NO_REPEAT_EN
  assign rollValue = (lfsrLow == value_q) ? lfsrLow + DW'(1) : lfsrLow;
`else
  assign rollValue = lfsrLow;
`endif

  // Period k lasts BASE_PERIOD + k*STEP cycles, so the count tops out one below that.
  assign periodLast = CNT_W'(BASE_PERIOD - 1 + int'(stepIdx_q) * STEP);

  always_comb begin
    state_d      = state_q;
    stepIdx_d    = stepIdx_q;
    count_d      = count_q;
    value_d      = value_q;
    done_d       = 1'b0;
    lucky_d      = lucky_q;
    luckyValid_d = luckyValid_q;
    hist_d       = hist_q;
    histCount_d  = histCount_q;

    // A start always (re)begins the roll, even mid-roll, and never produces a done pulse.
    if (i_start) begin
      state_d   = ROLL;
      stepIdx_d = '0;
      count_d   = '0;
    end else if (state_q == ROLL) begin
      if (count_q == periodLast) begin
        value_d = rollValue;
        count_d = '0;
        if (stepIdx_q == K_W'(SLOW_STEPS - 1)) begin
          state_d   = IDLE;
          stepIdx_d = '0;
          done_d    = 1'b1;
        end else begin
          stepIdx_d = stepIdx_q + K_W'(1);
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (i_capture) begin
      hist_d[DW-1:0] = value_q;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist_d[i*DW +: DW] = hist_q[(i-1)*DW +: DW];
      end
      if (histCount_q != HC_W'(HIST_DEPTH)) begin
        histCount_d = histCount_q + HC_W'(1);
      end
    end

    if (i_set_lucky) begin
      lucky_d      = value_q;
      luckyValid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      stepIdx_q    <= '0;
      count_q      <= '0;
      value_q      <= '0;
      done_q       <= 1'b0;
      lucky_q      <= '0;
      luckyValid_q <= 1'b0;
      hist_q       <= '0;
      histCount_q  <= '0;
    end else begin
      state_q      <= state_d;
      stepIdx_q    <= stepIdx_d;
      count_q      <= count_d;
      value_q      <= value_d;
      done_q       <= done_d;
      lucky_q      <= lucky_d;
      luckyValid_q <= luckyValid_d;
      hist_q       <= hist_d;
      histCount_q  <= histCount_d;
    end
  end

  assign o_value      = value_q;
  assign o_lucky      = lucky_q;
  assign o_history    = hist_q;
  assign o_hist_count = histCount_q;
  assign o_busy       = (state_q == ROLL);
  assign o_done       = done_q;
  assign o_match      = luckyValid_q && (state_q == IDLE) && (value_q == lucky_q);

endmodule
